// File: rtl/dfd_dst_pkg.sv
// Shared types and constants for the DST trace arbiter.
package dfd_dst_pkg;

    localparam int DST_ARB_MAX_SRC  = 8;
    localparam int VLT_PACKET_WIDTH = 128;

    typedef enum logic [1:0] {
        ST_ARB        = 2'd0,
        ST_FLUSH_WAIT = 2'd1,
        ST_FLUSH_ACK  = 2'd2
    } dst_arb_state_e;

endpackage

// File: rtl/dfd_dst_trace_arbiter_if.sv
// Bundle between the trace generators, the arbiter and the DST packetizer.
interface dfd_dst_trace_arbiter_if
    import dfd_dst_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int PKT_W      = VLT_PACKET_WIDTH,
    parameter int SPACE_W    = $clog2(PKT_W/8) + 1,
    parameter int DROP_CNT_W = 16
);
    logic                            arb_enable;
    logic [NUM_SRC*SPACE_W-1:0]      src_req_bytes;
    logic [NUM_SRC-1:0]              src_granted;
    logic [NUM_SRC*PKT_W-1:0]        src_packet;
    logic [NUM_SRC*PKT_W/8-1:0]      src_packet_be;
    logic [NUM_SRC-1:0]              src_flush_mode_enable;
    logic [NUM_SRC-1:0]              src_flush_mode_exit;
    logic [SPACE_W-1:0]              pkt_req_bytes;
    logic                            pkt_granted;
    logic [PKT_W-1:0]                pkt_packet;
    logic [PKT_W/8-1:0]              pkt_packet_be;
    logic                            pkt_flush_req;
    logic                            pkt_flush_done;
    logic                            drop_cnt_clr;
    logic [NUM_SRC*DROP_CNT_W-1:0]   drop_cnt;

    modport master (
        output arb_enable, src_req_bytes, src_packet, src_packet_be,
               src_flush_mode_enable, pkt_granted, pkt_flush_done, drop_cnt_clr,
        input  src_granted, src_flush_mode_exit, pkt_req_bytes, pkt_packet,
               pkt_packet_be, pkt_flush_req, drop_cnt
    );

    modport slave (
        input  arb_enable, src_req_bytes, src_packet, src_packet_be,
               src_flush_mode_enable, pkt_granted, pkt_flush_done, drop_cnt_clr,
        output src_granted, src_flush_mode_exit, pkt_req_bytes, pkt_packet,
               pkt_packet_be, pkt_flush_req, drop_cnt
    );

endinterface

// File: rtl/dfd_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module dfd_rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_SRC)) begin
                pos = pos - (IDX_W+1)'(NUM_SRC);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found               = 1'b1;
                gnt[pos[IDX_W-1:0]] = 1'b1;
                idx                 = pos[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dfd_dst_trace_arbiter.sv
// Shares one DST packetizer among NUM_SRC trace generators: round-robin space grant,
// one-cycle-later packet mux, per-source drop counters and flush sequencing.
//
//  state         | meaning
//  ST_ARB        | normal operation, watching for flush requests
//  ST_FLUSH_WAIT | packetizer drain requested, tracking which sources still want flush
//  ST_FLUSH_ACK  | one-cycle flush-exit pulse to the sources that were waiting
module dfd_dst_trace_arbiter
    import dfd_dst_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int PKT_W      = VLT_PACKET_WIDTH,
    parameter int SPACE_W    = $clog2(PKT_W/8) + 1,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    dfd_dst_trace_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int BE_W  = PKT_W/8;

    logic [NUM_SRC-1:0]            req;
    logic [NUM_SRC-1:0]            win_gnt;
    logic [NUM_SRC-1:0]            granted;
    logic [IDX_W-1:0]              win_idx;
    logic [IDX_W-1:0]              rr_ptr;
    logic [IDX_W-1:0]              win_q;
    logic                          win_any;
    logic                          issue;
    logic                          grant;
    logic                          win_vld_q;
    logic                          pkt_vld;
    logic [DROP_CNT_W-1:0]         drop_q [NUM_SRC];
    logic [NUM_SRC*DROP_CNT_W-1:0] drop_flat;
    dst_arb_state_e                state;
    logic [NUM_SRC-1:0]            flush_mask;
    logic [NUM_SRC-1:0]            mask_upd;
    logic [NUM_SRC-1:0]            flush_exit_q;
    logic                          flush_req_q;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i] = |bus.src_req_bytes[i*SPACE_W +: SPACE_W];
        end
    end

    dfd_rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // Outputs are held at zero while reset is asserted.
    assign issue   = win_any & bus.arb_enable & ~reset;
    assign grant   = issue & bus.pkt_granted;
    assign granted = grant ? win_gnt : '0;
    assign pkt_vld = win_vld_q & ~reset;

    assign bus.src_granted   = granted;
    assign bus.pkt_req_bytes = issue ? bus.src_req_bytes[win_idx*SPACE_W +: SPACE_W] : '0;
    assign bus.pkt_packet    = pkt_vld ? bus.src_packet[win_q*PKT_W +: PKT_W] : '0;
    assign bus.pkt_packet_be = pkt_vld ? bus.src_packet_be[win_q*BE_W +: BE_W] : '0;

    // A denied winner leaves the pointer alone so it keeps priority next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_q     <= win_idx;
            win_vld_q <= grant;
            if (grant) begin
                rr_ptr <= (win_idx == IDX_W'(NUM_SRC-1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.drop_cnt_clr) begin
                    drop_q[i] <= '0;
                end else if (req[i] && !granted[i] && (drop_q[i] != '1)) begin
                    drop_q[i] <= drop_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop_flat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_flat[i*DROP_CNT_W +: DROP_CNT_W] = drop_q[i];
        end
    end

    assign bus.drop_cnt = drop_flat;

    // Sources that dropped their enable leave the mask; late joiners are added.
    assign mask_upd = (flush_mask & bus.src_flush_mode_enable) | bus.src_flush_mode_enable;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_ARB;
            flush_mask   <= '0;
            flush_req_q  <= 1'b0;
            flush_exit_q <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    flush_exit_q <= '0;
                    if (|bus.src_flush_mode_enable) begin
                        flush_mask  <= bus.src_flush_mode_enable;
                        flush_req_q <= 1'b1;
                        state       <= ST_FLUSH_WAIT;
                    end
                end
                ST_FLUSH_WAIT: begin
                    flush_mask <= mask_upd;
                    if (mask_upd == '0) begin
                        flush_req_q <= 1'b0;
                        state       <= ST_ARB;
                    end else if (bus.pkt_flush_done) begin
                        flush_req_q  <= 1'b0;
                        flush_exit_q <= mask_upd;
                        state        <= ST_FLUSH_ACK;
                    end
                end
                ST_FLUSH_ACK: begin
                    flush_exit_q <= '0;
                    flush_mask   <= '0;
                    state        <= ST_ARB;
                end
                default: begin
                    flush_exit_q <= '0;
                    flush_mask   <= '0;
                    flush_req_q  <= 1'b0;
                    state        <= ST_ARB;
                end
            endcase
        end
    end

    assign bus.pkt_flush_req       = flush_req_q;
    assign bus.src_flush_mode_exit = flush_exit_q;

endmodule
